// File: rtl/block_loader.sv
// -----------------------------------------------------------------------------
// block_loader
//
// Packs a stream of WORD_W-bit message words into one WORD_W*N_WORDS-bit block
// for the downstream permutation stage. Word 0 of a block lands in the most
// significant slot. A block is closed either by its last slot filling or by
// in_last. Slots left unwritten in a closed block read as zero.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_data / in_last are presented
//   in_ready   block accepts a word this cycle
//   in_data    message word
//   in_last    final word of a short or terminal block
//   out_valid  out_block is complete and stable
//   out_ready  downstream consumes out_block
//   out_block  assembled block, word 0 in the top WORD_W bits
//   out_count  number of words written into the presented block (1..N_WORDS)
// -----------------------------------------------------------------------------
module block_loader #(
  parameter int WORD_W  = 64,
  parameter int N_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*N_WORDS-1:0] out_block,
  output logic [4:0]                out_count
);

  localparam int BLK_W = WORD_W * N_WORDS;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [BLK_W-1:0] blk;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_word;

  // While holding, a new word can only enter in the same cycle the held block
  // leaves, so readiness simply follows the downstream handshake.
  assign in_ready  = (state == FILL) | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign last_word = in_last | (cnt == 5'(N_WORDS - 1));
  assign out_block = blk;

  // Slots are cleared whenever a block leaves, so a short block only has to
  // write its own words to present zeros in every unused slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      blk       <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_xfer) begin
            for (int i = 0; i < N_WORDS; i++) begin
              if (cnt == 5'(i)) begin
                blk[(N_WORDS-1-i)*WORD_W +: WORD_W] <= in_data;
              end
            end
            cnt <= cnt + 5'd1;
            if (last_word) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_count <= cnt + 5'd1;
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            if (in_xfer) begin
              // Old block leaves and the new word 0 enters in the same edge.
              blk <= {in_data, {(BLK_W-WORD_W){1'b0}}};
              cnt <= 5'd1;
              if (in_last) begin
                out_count <= 5'd1;
              end else begin
                state     <= FILL;
                out_valid <= 1'b0;
                out_count <= '0;
              end
            end else begin
              blk       <= '0;
              cnt       <= '0;
              state     <= FILL;
              out_valid <= 1'b0;
              out_count <= '0;
            end
          end
        end
        default: begin
          state     <= FILL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_loader.sv
// -----------------------------------------------------------------------------
// tb_block_loader
//
// Directed table, hand-written corner sequences and randomized traffic, all
// compared against a word-queue reference model of block assembly.
// -----------------------------------------------------------------------------
module tb_block_loader;

  localparam int WORD_W  = 64;
  localparam int N_WORDS = 16;
  localparam int BLK_W   = WORD_W * N_WORDS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BLK_W-1:0]  out_block;
  logic [4:0]        out_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_loader #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block),
    .out_count(out_count)
  );

  // Reference model: words of the block being collected, plus the held block.
  logic [WORD_W-1:0] mWords[$];
  bit                mHeld;
  int                mCount;
  logic [BLK_W-1:0]  mBlk;

  typedef struct {
    logic              v;
    logic [WORD_W-1:0] d;
    logic              l;
    logic              ordy;
    logic              expValid;
    logic              expReady;
    logic [4:0]        expCount;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BLK_W-1:0] mkBlock(input logic [WORD_W-1:0] base, input int n);
    logic [BLK_W-1:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[BLK_W-1-WORD_W*k -: WORD_W] = base + WORD_W'(k);
    return b;
  endfunction

  function automatic logic [BLK_W-1:0] buildFromQueue();
    logic [BLK_W-1:0] b;
    b = '0;
    for (int k = 0; k < mWords.size(); k++) b[BLK_W-1-WORD_W*k -: WORD_W] = mWords[k];
    return b;
  endfunction

  task automatic modelReset();
    mHeld  = 0;
    mCount = 0;
    mBlk   = '0;
    mWords.delete();
  endtask

  task automatic modelStep(input logic v, input logic [WORD_W-1:0] d, input logic l, input logic ordy);
    bit inX, outX;
    inX  = v && (!mHeld || ordy);
    outX = mHeld && ordy;
    if (outX) mHeld = 0;
    if (inX) begin
      mWords.push_back(d);
      if (mWords.size() == N_WORDS || l) begin
        mBlk   = buildFromQueue();
        mCount = mWords.size();
        mHeld  = 1;
        mWords.delete();
      end
    end
  endtask

  task automatic checkOutput();
    cmp("out_valid", BLK_W'(out_valid), BLK_W'(mHeld));
    cmp("in_ready", BLK_W'(in_ready), BLK_W'(!mHeld || out_ready));
    if (mHeld) begin
      cmp("out_block", out_block, mBlk);
      cmp("out_count", BLK_W'(out_count), BLK_W'(mCount));
    end
  endtask

  // Drive one cycle: check outputs at the falling edge, advance the model and
  // return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [WORD_W-1:0] d, input logic l, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    @(negedge clk);
    checkOutput();
    modelStep(v, d, l, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    cmp("rst_out_valid", BLK_W'(out_valid), '0);
    cmp("rst_out_count", BLK_W'(out_count), '0);
    cmp("rst_out_block", out_block, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    cmp("rst_in_ready", BLK_W'(in_ready), BLK_W'(1));
  endtask

  initial begin
    int pulses[$];
    logic [BLK_W-1:0] expBlk;
    vec_t vv;

    modelReset();
    #1;
    applyReset();

    // Full block of 0x0..0xF: valid the cycle after word 15.
    for (int i = 0; i < N_WORDS; i++) applyStimulus(1'b1, WORD_W'(i), 1'b0, 1'b1);
    cmp("full_valid", BLK_W'(out_valid), BLK_W'(1));
    cmp("full_word0", BLK_W'(out_block[1023:960]), '0);
    cmp("full_word15", BLK_W'(out_block[63:0]), BLK_W'(64'hF));
    cmp("full_count", BLK_W'(out_count), BLK_W'(16));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Short block A,B,C then stall, ignored input, consume.
    vecs.push_back('{1'b1, 64'hA,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{1'b1, 64'hB,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{1'b1, 64'hC,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd3});
    vecs.push_back('{1'b1, 64'h77, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3});
    vecs.push_back('{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd3});
    vecs.push_back('{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
    for (int i = 0; i < vecs.size(); i++) begin
      vv = vecs[i];
      in_valid  = vv.v;
      in_data   = vv.d;
      in_last   = vv.l;
      out_ready = vv.ordy;
      @(negedge clk);
      cmp($sformatf("vec%0d_valid", i), BLK_W'(out_valid), BLK_W'(vv.expValid));
      cmp($sformatf("vec%0d_ready", i), BLK_W'(in_ready), BLK_W'(vv.expReady));
      if (vv.expValid) cmp($sformatf("vec%0d_count", i), BLK_W'(out_count), BLK_W'(vv.expCount));
      checkOutput();
      modelStep(vv.v, vv.d, vv.l, vv.ordy);
      @(posedge clk);
      #1;
      if (i == 2) begin
        cmp("abc_top", BLK_W'(out_block[1023:832]), BLK_W'({64'hA, 64'hB, 64'hC}));
        cmp("abc_rest", BLK_W'(out_block[831:0]), '0);
      end
    end

    // Backpressure for 10 cycles, then consume with simultaneous word 0.
    for (int i = 0; i < N_WORDS; i++) applyStimulus(1'b1, 64'h200 + WORD_W'(i), 1'b0, 1'b1);
    expBlk = mkBlock(64'h200, 16);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 64'h300 + WORD_W'(j), 1'b0, 1'b0);
      cmp("stall_in_ready", BLK_W'(in_ready), '0);
      cmp("stall_block", out_block, expBlk);
    end
    applyStimulus(1'b1, 64'h400, 1'b0, 1'b1);
    cmp("swap_valid_low", BLK_W'(out_valid), '0);
    for (int i = 1; i < N_WORDS; i++) applyStimulus(1'b1, 64'h400 + WORD_W'(i), 1'b0, 1'b1);
    cmp("swap_block", out_block, mkBlock(64'h400, 16));
    cmp("swap_count", BLK_W'(out_count), BLK_W'(16));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Streaming 48 words: blocks presented exactly 16 cycles apart.
    for (int i = 0; i < 49; i++) begin
      if (out_valid) pulses.push_back(i);
      applyStimulus(i < 48, 64'h500 + WORD_W'(i), 1'b0, 1'b1);
    end
    cmp("stream_pulses", BLK_W'(pulses.size()), BLK_W'(3));
    if (pulses.size() == 3) begin
      cmp("stream_p0", BLK_W'(pulses[0]), BLK_W'(16));
      cmp("stream_p1", BLK_W'(pulses[1]), BLK_W'(32));
      cmp("stream_p2", BLK_W'(pulses[2]), BLK_W'(48));
    end

    // Reset mid-block discards the partial words.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 64'h600 + WORD_W'(i), 1'b0, 1'b1);
    applyReset();
    for (int i = 0; i < N_WORDS; i++) applyStimulus(1'b1, 64'h100 + WORD_W'(i), 1'b0, 1'b0);
    cmp("rst_blk_word0", BLK_W'(out_block[1023:960]), BLK_W'(64'h100));
    cmp("rst_blk_word15", BLK_W'(out_block[63:0]), BLK_W'(64'h10F));
    cmp("rst_blk_all", out_block, mkBlock(64'h100, 16));
    cmp("rst_blk_count", BLK_W'(out_count), BLK_W'(16));

    // Reset while holding clears outputs without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("hold_rst_valid", BLK_W'(out_valid), '0);
    cmp("hold_rst_block", out_block, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();

    // Single-word block consumed alongside another single-word block.
    applyStimulus(1'b1, 64'h55, 1'b1, 1'b0);
    cmp("single_count", BLK_W'(out_count), BLK_W'(1));
    applyStimulus(1'b1, 64'h66, 1'b1, 1'b1);
    cmp("single2_valid", BLK_W'(out_valid), BLK_W'(1));
    cmp("single2_count", BLK_W'(out_count), BLK_W'(1));
    cmp("single2_block", out_block, {64'h66, {(BLK_W-WORD_W){1'b0}}});
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) applyReset();
      applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom},
                    $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
